// File: rtl/axil_reg_if_shared.sv
// axil_reg_if_shared
// AXI-Lite slave that funnels writes and reads onto one shared register
// access port. AW, W and AR beats are captured into single-entry holding
// registers; an arbiter grants one access at a time. An access ends on
// reg_ack or, when enabled, on a timeout that reg_wait holds off.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   s_axil_aw*/w*/b*   AXI-Lite write address, data and response channels
//   s_axil_ar*/r*      AXI-Lite read address and data channels (prot ignored)
//   reg_addr           word-aligned address of the current access
//   reg_wr_data/strb   write payload, stable for the whole write access
//   reg_wr_en/rd_en    one-hot access-active strobes
//   reg_rd_data        read data, captured on reg_ack
//   reg_wait           target busy, keeps the timeout counter cleared
//   reg_ack            access complete
//
// state     | meaning
// S_IDLE    | no access in progress, arbitrate pending requests
// S_WR      | write access on the register port
// S_RD      | read access on the register port
module axil_reg_if_shared #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT     = 4,
  parameter int TIMEOUT_ERR = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_wait,
  input  logic                  reg_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  localparam int ALIGN = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ALIGN;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [1:0] TO_RESP = (TIMEOUT_ERR != 0) ? 2'b10 : 2'b00;

  logic [1:0]            r_state;
  logic                  r_aw_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;
  logic                  r_ar_full;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_last_wr;  // round-robin: last grant was a write
  logic [CNT_W-1:0]      r_cnt;

  logic w_wr_pend;
  logic w_rd_pend;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_active;
  logic w_timeout;
  logic w_done;
  logic w_unused;

  assign w_unused = ^{s_axil_awprot, s_axil_arprot};

  assign w_wr_pend = r_aw_full && r_w_full && !r_bvalid;
  assign w_rd_pend = r_ar_full && !r_rvalid;

  // With both pending: mode 1 favours writes, mode 2 reads, mode 0 alternates.
  assign w_grant_wr = w_wr_pend &&
                      (!w_rd_pend || (ARB_MODE == 1) || ((ARB_MODE == 0) && !r_last_wr));
  assign w_grant_rd = w_rd_pend && !w_grant_wr;

  assign w_active  = (r_state == S_WR) || (r_state == S_RD);
  // Ack takes precedence over a timeout landing in the same cycle.
  assign w_timeout = TO_EN && w_active && !reg_ack && !reg_wait && (r_cnt == TO_LAST);
  assign w_done    = w_active && (reg_ack || w_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_ar_full <= 1'b0;
      r_ar_addr <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_last_wr <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (s_axil_awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= s_axil_awaddr;
      end
      if (s_axil_wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_w_data <= s_axil_wdata;
        r_w_strb <= s_axil_wstrb;
      end
      if (s_axil_arvalid && !r_ar_full) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= s_axil_araddr;
      end
      if (r_bvalid && s_axil_bready) r_bvalid <= 1'b0;
      if (r_rvalid && s_axil_rready) r_rvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_wr) begin
            r_state   <= S_WR;
            r_last_wr <= 1'b1;
          end else if (w_grant_rd) begin
            r_state   <= S_RD;
            r_last_wr <= 1'b0;
          end
        end
        S_WR, S_RD: begin
          if (w_done) begin
            r_state <= S_IDLE;
            if (r_state == S_WR) begin
              r_aw_full <= 1'b0;
              r_w_full  <= 1'b0;
              r_bvalid  <= 1'b1;
              r_bresp   <= reg_ack ? 2'b00 : TO_RESP;
            end else begin
              r_ar_full <= 1'b0;
              r_rvalid  <= 1'b1;
              r_rresp   <= reg_ack ? 2'b00 : TO_RESP;
              r_rdata   <= reg_ack ? reg_rd_data : '0;
            end
          end else if (reg_wait) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axil_awready = !r_aw_full;
  assign s_axil_wready  = !r_w_full;
  assign s_axil_arready = !r_ar_full;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;

  assign reg_addr    = ((r_state == S_RD) ? r_ar_addr : r_aw_addr) & ADDR_MASK;
  assign reg_wr_data = r_w_data;
  assign reg_wr_strb = r_w_strb;
  assign reg_wr_en   = (r_state == S_WR);
  assign reg_rd_en   = (r_state == S_RD);

endmodule
